// File: rtl/obi_spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : obi_spi_arb_pkg
// Purpose  : Shared types for the SPI-RAM OBI arbiter: OBI configuration,
//            request/response structs, the arbiter state enum and the
//            requester-index width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package obi_spi_arb_pkg;

  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

  typedef struct packed {
    logic [ObiDefaultConfig.AddrWidth-1:0]   addr;
    logic                                    we;
    logic [ObiDefaultConfig.DataWidth/8-1:0] be;
    logic [ObiDefaultConfig.DataWidth-1:0]   wdata;
    logic [ObiDefaultConfig.IdWidth-1:0]     aid;
  } obi_spi_a_chan_t;

  typedef struct packed {
    logic            req;
    obi_spi_a_chan_t a;
  } obi_spi_req_t;

  typedef struct packed {
    logic [ObiDefaultConfig.DataWidth-1:0] rdata;
    logic [ObiDefaultConfig.IdWidth-1:0]   rid;
    logic                                  err;
    logic                                  r_optional;
  } obi_spi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    obi_spi_r_chan_t r;
  } obi_spi_rsp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    DRAIN   = 3'd3
`ifdef OBI_SPI_ARB_WDOG_EN
    ,
    ERR_RSP = 3'd4
`endif
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/obi_spi_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : obi_spi_arb_rr_pick
// Purpose  : Combinational cyclic-priority pick. Returns the first asserted
//            request found when scanning upwards from rr_i, wrapping at NumReq.
// Ports    : req_i   [NumReq]  request vector
//            rr_i    [IdxW]    scan start index (must be < NumReq)
//            valid_o           any request asserted
//            idx_o   [IdxW]    index of the winner
// Revision : 1.0 - initial release
// ============================================================================
module obi_spi_arb_rr_pick #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   rr_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  // One extra bit so rr_i + k never overflows before the wrap correction.
  localparam int unsigned CandW = IdxW + 1;

  logic [CandW-1:0] cand;

  // Scan from the farthest offset down to zero so the closest asserted
  // request to rr_i is the last one written, i.e. the winner.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = {1'b0, rr_i} + CandW'(k);
      if (cand >= CandW'(NumReq)) begin
        cand = cand - CandW'(NumReq);
      end
      if (req_i[cand[IdxW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IdxW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/obi_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : obi_spi_ram_arbiter
// Purpose  : Shares the single OBI subordinate port of the SPI-RAM shim
//            between NumReq OBI managers. One transaction in flight at a time,
//            round-robin arbitration, response routed back to the issuer only,
//            rid regenerated locally, only the first rvalid cycle forwarded.
//            Optional grant watchdog under macro OBI_SPI_ARB_WDOG_EN.
// Ports    : clk_i, rst_ni (async, active-low)
//            sbr_req_i [NumReq] / sbr_rsp_o [NumReq]  manager-facing OBI
//            mgr_req_o / mgr_rsp_i                    shim-facing OBI
//            busy_o   state is not IDLE
//            sel_o    locked requester index
// Revision : 1.0 - initial release
// ============================================================================
module obi_spi_ram_arbiter
  import obi_spi_arb_pkg::*;
#(
  parameter int unsigned NumReq     = 3,
  parameter obi_cfg_t    ObiCfg     = ObiDefaultConfig,
  parameter type         obi_req_t  = obi_spi_arb_pkg::obi_spi_req_t,
  parameter type         obi_rsp_t  = obi_spi_arb_pkg::obi_spi_rsp_t,
  parameter int unsigned WdogCycles = 1024,
  localparam int unsigned IdxW      = calc_idx_w(NumReq)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  obi_req_t        sbr_req_i [NumReq],
  output obi_rsp_t        sbr_rsp_o [NumReq],
  output obi_req_t        mgr_req_o,
  input  obi_rsp_t        mgr_rsp_i,
  output logic            busy_o,
  output logic [IdxW-1:0] sel_o
);

  if (NumReq < 2) begin : g_numreq_check
    $error("obi_spi_ram_arbiter: NumReq must be at least 2");
  end
  if (WdogCycles < 1) begin : g_wdog_check
    $error("obi_spi_ram_arbiter: WdogCycles must be at least 1");
  end

  arb_state_e                state_q, state_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [IdxW-1:0]           rr_q, rr_d;
  logic [ObiCfg.IdWidth-1:0] aid_q, aid_d;
  logic [NumReq-1:0]         req_vec;
  logic                      pick_valid;
  logic [IdxW-1:0]           pick_idx;
  logic [IdxW-1:0]           rr_next;

  // The shim's own rid/r_optional are intentionally replaced by local values.
  logic unused_rsp_fields;
  assign unused_rsp_fields = ^{mgr_rsp_i.r.rid, mgr_rsp_i.r.r_optional};

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_vec[i] = sbr_req_i[i].req;
    end
  end

  obi_spi_arb_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) i_rr_pick (
    .req_i   (req_vec),
    .rr_i    (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign rr_next = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;
  assign busy_o  = (state_q != IDLE);
  assign sel_o   = idx_q;

`ifdef OBI_SPI_ARB_WDOG_EN
  logic [15:0] wdog_q, wdog_d;
  logic        wdog_expired;
  assign wdog_expired = (wdog_q == 16'(WdogCycles - 1));
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    aid_d     = aid_q;
    mgr_req_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      sbr_rsp_o[i] = '0;
    end
`ifdef OBI_SPI_ARB_WDOG_EN
    wdog_d = wdog_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          mgr_req_o               = sbr_req_i[pick_idx];
          sbr_rsp_o[pick_idx].gnt = mgr_rsp_i.gnt;
          idx_d                   = pick_idx;
          if (mgr_rsp_i.gnt) begin
            aid_d   = sbr_req_i[pick_idx].a.aid;
            state_d = WAIT;
          end else begin
            state_d = ISSUE;
`ifdef OBI_SPI_ARB_WDOG_EN
            wdog_d  = '0;
`endif
          end
        end
      end

      // Locked to idx_q: newer requests cannot disturb the pending address.
      ISSUE: begin
        mgr_req_o            = sbr_req_i[idx_q];
        sbr_rsp_o[idx_q].gnt = mgr_rsp_i.gnt;
        if (mgr_rsp_i.gnt) begin
          aid_d   = sbr_req_i[idx_q].a.aid;
          state_d = WAIT;
        end
`ifdef OBI_SPI_ARB_WDOG_EN
        // req stays high in the expiry cycle so a late shim gnt still wins
        // without gnt feeding back into req; it is not reissued afterwards.
        else if (wdog_expired) begin
          sbr_rsp_o[idx_q].gnt = 1'b1;
          aid_d                = sbr_req_i[idx_q].a.aid;
          state_d              = ERR_RSP;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end

      WAIT: begin
        if (mgr_rsp_i.rvalid) begin
          sbr_rsp_o[idx_q].rvalid  = 1'b1;
          sbr_rsp_o[idx_q].r.rdata = mgr_rsp_i.r.rdata;
          sbr_rsp_o[idx_q].r.err   = mgr_rsp_i.r.err;
          sbr_rsp_o[idx_q].r.rid   = aid_q;
          rr_d                     = rr_next;
          state_d                  = DRAIN;
        end
      end

      // Swallow any trailing rvalid cycles of the same transaction.
      DRAIN: begin
        if (!mgr_rsp_i.rvalid) begin
          state_d = IDLE;
        end
      end

`ifdef OBI_SPI_ARB_WDOG_EN
      ERR_RSP: begin
        sbr_rsp_o[idx_q].rvalid = 1'b1;
        sbr_rsp_o[idx_q].r.err  = 1'b1;
        sbr_rsp_o[idx_q].r.rid  = aid_q;
        rr_d                    = rr_next;
        state_d                 = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
      aid_q   <= '0;
`ifdef OBI_SPI_ARB_WDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      aid_q   <= aid_d;
`ifdef OBI_SPI_ARB_WDOG_EN
      wdog_q  <= wdog_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obi_spi_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_obi_spi_ram_arbiter
// Purpose  : Self-checking bench for obi_spi_ram_arbiter. Manager queues feed
//            the requesters, a small shim model answers on the shim port, and
//            a scoreboard holds the expected response for every grant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obi_spi_ram_arbiter;
  import obi_spi_arb_pkg::*;

  localparam int NUM_REQ = 3;
  localparam int WDOG    = 8;
  localparam logic [31:0] OOR_BASE = 32'h8000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  aid;
  } mreq_t;

  typedef struct {
    int          idx;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  obi_spi_req_t sbr_req_i [NUM_REQ];
  obi_spi_rsp_t sbr_rsp_o [NUM_REQ];
  obi_spi_req_t mgr_req_o;
  obi_spi_rsp_t mgr_rsp_i;
  logic         busy_o;
  logic [1:0]   sel_o;

  obi_spi_ram_arbiter #(
    .NumReq     (NUM_REQ),
    .WdogCycles (WDOG)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .sbr_req_i (sbr_req_i),
    .sbr_rsp_o (sbr_rsp_o),
    .mgr_req_o (mgr_req_o),
    .mgr_rsp_i (mgr_rsp_i),
    .busy_o    (busy_o),
    .sel_o     (sel_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bench state shared between processes
  mreq_t       mq [NUM_REQ][$];
  exp_t        sb [$];
  int          g_idx [$];
  int          g_cyc [$];
  int          rv_cyc [$];
  int          rv_cnt [NUM_REQ];
  bit          hs [NUM_REQ];
  int          stall_left  = 0;
  int          rv_gap      = 0;
  int          rv_len      = 1;
  bit          data_ovr_en = 1'b0;
  logic [31:0] data_ovr    = '0;

  // Managers: present the head of each queue, pop it after the handshake.
  initial begin
    for (int i = 0; i < NUM_REQ; i++) sbr_req_i[i] = '0;
    forever begin
      @(posedge clk_i);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (mq[i].size() > 0) begin
          sbr_req_i[i].req     = 1'b1;
          sbr_req_i[i].a.addr  = mq[i][0].addr;
          sbr_req_i[i].a.aid   = mq[i][0].aid;
          sbr_req_i[i].a.we    = 1'b0;
          sbr_req_i[i].a.be    = 4'hF;
          sbr_req_i[i].a.wdata = '0;
        end else begin
          sbr_req_i[i] = '0;
        end
      end
    end
  end

  // Shim model: grants in-range addresses after stall_left cycles, answers
  // rv_gap cycles after the handshake with rv_len rvalid cycles.
  initial begin : shim
    int          rv_wait;
    int          rv_left;
    bit          hs_pend;
    logic [31:0] hs_addr;
    logic [31:0] rv_data;
    mgr_rsp_i = '0;
    rv_wait = 0; rv_left = 0; hs_pend = 1'b0; hs_addr = '0; rv_data = '0;
    forever begin
      @(posedge clk_i);
      if (!rst_ni) begin
        mgr_rsp_i = '0;
        rv_wait = 0; rv_left = 0; hs_pend = 1'b0;
      end else begin
        if (hs_pend) begin
          rv_wait = rv_gap;
          rv_left = rv_len;
          rv_data = data_ovr_en ? data_ovr : ~hs_addr;
        end
        #2;
        if (rv_left > 0 && rv_wait == 0) begin
          mgr_rsp_i.rvalid  = 1'b1;
          mgr_rsp_i.r.rdata = rv_data;
          rv_left--;
        end else begin
          mgr_rsp_i.rvalid  = 1'b0;
          mgr_rsp_i.r.rdata = '0;
          if (rv_wait > 0) rv_wait--;
        end
        if (mgr_req_o.req && mgr_req_o.a.addr < OOR_BASE) begin
          mgr_rsp_i.gnt = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end else begin
          mgr_rsp_i.gnt = 1'b0;
        end
        hs_pend = mgr_req_o.req && mgr_rsp_i.gnt;
        hs_addr = mgr_req_o.a.addr;
      end
    end
  end

  // Monitor: records grants (pushing the expected response) and checks
  // every forwarded rvalid against the scoreboard.
  always @(negedge clk_i) begin
    exp_t e;
    for (int i = 0; i < NUM_REQ; i++) begin
      hs[i] = sbr_req_i[i].req && sbr_rsp_o[i].gnt;
      if (hs[i]) begin
        g_idx.push_back(i);
        g_cyc.push_back(cyc);
        e.idx = i;
        e.rid = sbr_req_i[i].a.aid;
        if (sbr_req_i[i].a.addr >= OOR_BASE) begin
          e.err   = 1'b1;
          e.rdata = '0;
        end else begin
          e.err   = 1'b0;
          e.rdata = data_ovr_en ? data_ovr : ~sbr_req_i[i].a.addr;
        end
        sb.push_back(e);
      end
      if (sbr_rsp_o[i].rvalid) begin
        rv_cnt[i]++;
        rv_cyc.push_back(cyc);
        check_val("pending_on_rvalid", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("rsp_idx", i, e.idx);
          check_val("rsp_rid", sbr_rsp_o[i].r.rid, e.rid);
          check_val("rsp_rdata", sbr_rsp_o[i].r.rdata, e.rdata);
          check_val("rsp_err", sbr_rsp_o[i].r.err, e.err);
          check_val("rsp_ropt", sbr_rsp_o[i].r.r_optional, 0);
        end
      end
    end
    if (mgr_rsp_i.rvalid) check_val("busy_during_rvalid", busy_o, 1);
  end

  task automatic clear_logs();
    g_idx.delete();
    g_cyc.delete();
    rv_cyc.delete();
    for (int i = 0; i < NUM_REQ; i++) rv_cnt[i] = 0;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_val({pfx, "_busy"}, busy_o, 0);
    check_val({pfx, "_sel"}, sel_o, 0);
    check_val({pfx, "_mgr_req"}, mgr_req_o, '0);
    for (int i = 0; i < NUM_REQ; i++) check_val({pfx, "_sbr_rsp"}, sbr_rsp_o[i], '0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check_idle_outputs("rst");
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    check_val("rst_rr", dut.rr_q, 0);
  endtask

  task automatic wait_quiet(input int budget);
    int  n;
    int  pending;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      pending = sb.size() + int'(busy_o);
      for (int i = 0; i < NUM_REQ; i++) pending += mq[i].size();
      if (pending == 0) done = 1'b1;
      else if (++n >= budget) begin
        check_val("quiet_timeout", pending, 0);
        done = 1'b1;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int c_req;
    int n;
    rst_ni = 1'b0;
    do_reset();

    // Simultaneous requests from 0 and 2 with rr at 0.
    clear_logs();
    @(negedge clk_i); #1;
    mq[0].push_back('{addr: 32'h0000_0010, aid: 4'hA});
    mq[2].push_back('{addr: 32'h0000_0020, aid: 4'h3});
    wait_quiet(100);
    check_val("t1_ngrants", g_idx.size(), 2);
    if (g_idx.size() == 2) begin
      check_val("t1_first", g_idx[0], 0);
      check_val("t1_second", g_idx[1], 2);
    end
    check_val("t1_rv0", rv_cnt[0], 1);
    check_val("t1_rv2", rv_cnt[2], 1);

    // Shim holds rvalid for 4 cycles; next grant only after rvalid falls.
    clear_logs();
    data_ovr_en = 1'b1; data_ovr = 32'hDEAD_BEEF; rv_len = 4;
    #1 mq[1].push_back('{addr: 32'h0000_0100, aid: 4'h5});
    repeat (2) @(negedge clk_i);
    #1 mq[0].push_back('{addr: 32'h0000_0200, aid: 4'h6});
    wait_quiet(100);
    check_val("t2_rv1", rv_cnt[1], 1);
    check_val("t2_ngrants", g_idx.size(), 2);
    if (g_idx.size() == 2 && rv_cyc.size() >= 1) begin
      check_val("t2_order", g_idx[1], 0);
      check_val("t2_gap", g_cyc[1], rv_cyc[0] + 4 + 1);
    end
    data_ovr_en = 1'b0; rv_len = 1;

    // Shim withholds gnt for 5 cycles while requester 1 also asks.
    clear_logs();
    stall_left = 5;
    #1 mq[0].push_back('{addr: 32'h0000_0300, aid: 4'h7});
    @(negedge clk_i);
    #1 mq[1].push_back('{addr: 32'h0000_0400, aid: 4'h8});
    repeat (4) begin
      @(negedge clk_i);
      check_val("t3_addr_stable", mgr_req_o.a.addr, 32'h0000_0300);
      check_val("t3_no_gnt_other", sbr_rsp_o[1].gnt, 0);
    end
    wait_quiet(100);
    check_val("t3_ngrants", g_idx.size(), 2);
    if (g_idx.size() == 2) begin
      check_val("t3_first", g_idx[0], 0);
      check_val("t3_second", g_idx[1], 1);
    end

    // Continuous requests from all three, 9 transactions from rr=0.
    do_reset();
    clear_logs();
    #1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NUM_REQ; i++)
        mq[i].push_back('{addr: 32'h1000 + 32'(16 * (3 * k + i)), aid: 4'(3 * k + i)});
    wait_quiet(400);
    check_val("t4_ngrants", g_idx.size(), 9);
    for (int k = 0; k < g_idx.size() && k < 9; k++) check_val("t4_order", g_idx[k], k % 3);

`ifdef OBI_SPI_ARB_WDOG_EN
    // Out-of-range address is never granted by the shim.
    clear_logs();
    #1;
    mq[0].push_back('{addr: 32'h9000_0000, aid: 4'hC});
    mq[1].push_back('{addr: 32'h0000_0700, aid: 4'hD});
    @(negedge clk_i);
    c_req = cyc;
    wait_quiet(100);
    check_val("t5_ngrants", g_idx.size(), 2);
    if (g_idx.size() == 2 && rv_cyc.size() >= 1) begin
      check_val("t5_wdog_gnt_cyc", g_cyc[0], c_req + WDOG);
      check_val("t5_err_rsp_cyc", rv_cyc[0], c_req + WDOG + 1);
      check_val("t5_next_served", g_idx[1], 1);
    end
`endif

    // Reset while waiting for the response.
    clear_logs();
    rv_gap = 5;
    #1 mq[1].push_back('{addr: 32'h0000_0600, aid: 4'h9});
    n = 0;
    while (g_idx.size() == 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check_val("t6_granted", g_idx.size(), 1);
    @(negedge clk_i);
    check_val("t6_busy_in_wait", busy_o, 1);
    check_val("t6_sel_in_wait", sel_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check_idle_outputs("t6_async");
    sb.delete();
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    rv_gap = 0;
    @(negedge clk_i);
    check_val("t6_busy_after", busy_o, 0);
    check_val("t6_rr_after", dut.rr_q, 0);
    repeat (8) @(negedge clk_i);
    check_val("t6_no_late_rvalid", rv_cnt[1], 0);

    check_val("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
